// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler sharing one active-low hex digit among NREQ requesters.
// Optional macro HOLD_LAST_EN: keep the last pattern instead of blanking in IDLE and abort GAP.
//
//  state | meaning
//  IDLE  | no owner, waiting for enable and a request
//  SHOW  | owner's captured nibble on the digit for DWELL_CYCLES clocks
//  GAP   | single cycle after a slot; carries done on normal completion
module hex_display_scheduler #(
    parameter  int NREQ         = 4,
    parameter  int DWELL_CYCLES = 50000000,
    localparam int OW           = $clog2(NREQ)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] nibble,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [OW-1:0]     owner,
    output logic [6:0]        seg
);

    localparam int             CW        = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [6:0]     SEG_BLANK = 7'h7F;

`ifdef HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   sel;
    logic [OW-1:0]   idx;
    logic            found;
    logic            arb;
    logic [OW-1:0]   ptr_after;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        arb = found & enable;
    end

    always_comb begin
        ptr_after = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            seg   <= SEG_BLANK;
        end else begin
            done <= '0;
            case (state)
                IDLE, GAP: begin
                    if (arb) begin
                        state <= SHOW;
                        grant <= NREQ'(1) << sel;
                        owner <= sel;
                        cnt   <= '0;
                        seg   <= seg_decode(nibble[{sel, 2'b00} +: 4]);
                    end else begin
                        state <= IDLE;
                        if (!HOLD_LAST) seg <= SEG_BLANK;
                    end
                end
                SHOW: begin
                    if (!req[owner]) begin
                        state <= GAP;
                        grant <= '0;
                        ptr   <= ptr_after;
                        if (!HOLD_LAST) seg <= SEG_BLANK;
                    end else if (cnt == CNT_LAST) begin
                        state <= GAP;
                        grant <= '0;
                        done  <= grant;
                        ptr   <= ptr_after;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler: vector table, directed corner sequences,
// and randomized traffic against a slot-level reference model (DWELL 4 and DWELL 1 instances).
module tb_hex_display_scheduler;

    localparam int N = 4;

`ifdef HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic           clk;
    logic           resetn;
    logic           en;
    logic [N-1:0]   req;
    logic [4*N-1:0] nib;

    logic [N-1:0] g0, d0, g1, d1;
    logic [1:0]   o0, o1;
    logic [6:0]   s0, s1;

    int n_cmp = 0;
    int n_bad = 0;

    hex_display_scheduler #(.NREQ(N), .DWELL_CYCLES(4)) u_dut0 (
        .CLOCK_50(clk), .resetn(resetn), .enable(en), .req(req), .nibble(nib),
        .grant(g0), .done(d0), .owner(o0), .seg(s0)
    );

    hex_display_scheduler #(.NREQ(N), .DWELL_CYCLES(1)) u_dut1 (
        .CLOCK_50(clk), .resetn(resetn), .enable(en), .req(req), .nibble(nib),
        .grant(g1), .done(d1), .owner(o1), .seg(s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] dec_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: one slot record per instance, advanced once per clock.
    typedef struct {
        bit          busy;
        int          owner;
        int          el;
        int          ptr;
        logic [6:0]  seg;
        logic [N-1:0] done;
    } mstate_t;

    mstate_t ms [2];

    function automatic mstate_t m_reset();
        mstate_t r;
        r.busy = 0; r.owner = 0; r.el = 0; r.ptr = 0; r.seg = 7'h7F; r.done = '0;
        return r;
    endfunction

    function automatic mstate_t next_m(mstate_t s, int dwell, logic e,
                                       logic [N-1:0] rq, logic [4*N-1:0] nb);
        mstate_t n;
        int pick;
        n = s;
        pick = -1;
        n.done = '0;
        if (s.busy) begin
            if (!rq[s.owner]) begin
                n.busy = 0;
                n.ptr = (s.owner + 1) % N;
                if (!HOLD) n.seg = 7'h7F;
            end else if (s.el == dwell - 1) begin
                n.busy = 0;
                n.ptr = (s.owner + 1) % N;
                n.done[s.owner] = 1'b1;
            end else begin
                n.el = s.el + 1;
            end
        end else begin
            if (e) begin
                for (int k = N - 1; k >= 0; k--)
                    if (rq[(s.ptr + k) % N]) pick = (s.ptr + k) % N;
            end
            if (pick >= 0) begin
                n.busy = 1;
                n.owner = pick;
                n.el = 0;
                n.seg = dec_t[nb[4*pick +: 4]];
            end else if (!HOLD) begin
                n.seg = 7'h7F;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms[0] <= m_reset();
            ms[1] <= m_reset();
        end else begin
            ms[0] <= next_m(ms[0], 4, en, req, nib);
            ms[1] <= next_m(ms[1], 1, en, req, nib);
        end
    end

    function automatic logic [N-1:0] m_grant(mstate_t s);
        return s.busy ? (N'(1) << s.owner) : '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_models();
        chk("m0 grant", 32'(g0), 32'(m_grant(ms[0])));
        chk("m0 done",  32'(d0), 32'(ms[0].done));
        chk("m0 seg",   32'(s0), 32'(ms[0].seg));
        chk("m0 owner", 32'(o0), ms[0].owner);
        chk("m1 grant", 32'(g1), 32'(m_grant(ms[1])));
        chk("m1 done",  32'(d1), 32'(ms[1].done));
        chk("m1 seg",   32'(s1), 32'(ms[1].seg));
        chk("m1 owner", 32'(o1), ms[1].owner);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cmp_models();
    endtask

    task automatic chk0(input string tag, input logic [3:0] g, input logic [3:0] d,
                        input logic [6:0] s, input logic [1:0] o);
        chk({tag, " grant"}, 32'(g0), 32'(g));
        chk({tag, " done"},  32'(d0), 32'(d));
        chk({tag, " seg"},   32'(s0), 32'(s));
        chk({tag, " owner"}, 32'(o0), 32'(o));
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic        en;
        logic [3:0]  req;
        logic [15:0] nib;
        logic [3:0]  g;
        logic [3:0]  d;
        logic [6:0]  s;
        logic [1:0]  o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, logic e, logic [3:0] rq, logic [15:0] nb,
                               logic [3:0] g, logic [3:0] d, logic [6:0] s, logic [1:0] o);
        vec_t x;
        x.rst = r; x.en = e; x.req = rq; x.nib = nb; x.g = g; x.d = d; x.s = s; x.o = o;
        return x;
    endfunction

    logic [6:0] blank_or_hold;

    initial begin
        resetn = 1'b0;
        en = 1'b0;
        req = '0;
        nib = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single request, requester 2 showing 'A'
        tbl.push_back(v(1, 1, 4'b0100, 16'h0A00, 4'b0000, 4'b0000, 7'h7F, 2'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 4'b0100, 16'h0A00, 4'b0100, 4'b0000, 7'h08, 2'd2));
        tbl.push_back(v(0, 1, 4'b0100, 16'h0A00, 4'b0000, 4'b0100, 7'h08, 2'd2));
        tbl.push_back(v(0, 1, 4'b0100, 16'h0A00, 4'b0100, 4'b0000, 7'h08, 2'd2));
        // Round robin over 1011
        tbl.push_back(v(1, 1, 4'b1011, 16'h3021, 4'b0000, 4'b0000, 7'h7F, 2'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0001, 4'b0000, 7'h79, 2'd0));
        tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0000, 4'b0001, 7'h79, 2'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0010, 4'b0000, 7'h24, 2'd1));
        tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0000, 4'b0010, 7'h24, 2'd1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b1000, 4'b0000, 7'h30, 2'd3));
        tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0000, 4'b1000, 7'h30, 2'd3));
        tbl.push_back(v(0, 1, 4'b1011, 16'h3021, 4'b0001, 4'b0000, 7'h79, 2'd0));

        foreach (tbl[i]) begin
            en = tbl[i].en;
            req = tbl[i].req;
            nib = tbl[i].nib;
            if (tbl[i].rst) begin
                resetn = 1'b0;
                #1;
            end else begin
                step();
            end
            chk0($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].s, tbl[i].o);
            if (tbl[i].rst) begin
                @(negedge clk);
                resetn = 1'b1;
            end
        end

        // Abort: requester 1 drops its request in its second SHOW cycle
        pulse_reset();
        en = 1; req = 4'b1010; nib = 16'h9060;
        step(); chk0("abort show1", 4'b0010, 4'b0000, 7'h02, 2'd1);
        step(); chk0("abort show2", 4'b0010, 4'b0000, 7'h02, 2'd1);
        req = 4'b1000;
        blank_or_hold = HOLD ? 7'h02 : 7'h7F;
        step(); chk0("abort gap", 4'b0000, 4'b0000, blank_or_hold, 2'd1);
        step(); chk0("abort next", 4'b1000, 4'b0000, 7'h10, 2'd3);

        // Enable low mid-slot: slot completes, then no new grant
        pulse_reset();
        en = 1; req = 4'b0001; nib = 16'h0005;
        step(); chk0("en show", 4'b0001, 4'b0000, 7'h12, 2'd0);
        en = 0;
        repeat (3) step();
        chk0("en last", 4'b0001, 4'b0000, 7'h12, 2'd0);
        step(); chk0("en done", 4'b0000, 4'b0001, 7'h12, 2'd0);
        blank_or_hold = HOLD ? 7'h12 : 7'h7F;
        step(); chk0("en idle", 4'b0000, 4'b0000, blank_or_hold, 2'd0);
        step(); chk0("en idle2", 4'b0000, 4'b0000, blank_or_hold, 2'd0);
        en = 1;
        step(); chk0("en regrant", 4'b0001, 4'b0000, 7'h12, 2'd0);

        // Asynchronous reset in the second SHOW cycle
        pulse_reset();
        en = 1; req = 4'b0010; nib = 16'h0070;
        step(); step();
        chk0("rst pre", 4'b0010, 4'b0000, 7'h78, 2'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk0("rst async", 4'b0000, 4'b0000, 7'h7F, 2'd0);
        @(negedge clk);
        chk0("rst held", 4'b0000, 4'b0000, 7'h7F, 2'd0);
        resetn = 1'b1;
        step(); chk0("rst regrant", 4'b0010, 4'b0000, 7'h78, 2'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            en = ($urandom_range(0, 9) != 0);
            nib = 16'($urandom);
            resetn = ($urandom_range(0, 249) != 0);
            step();
        end
        resetn = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
